// File: rtl/ldpc_ram_arb_pkg.sv
// Shared constants and the round-robin pick helper for the ldpc_ram read arbiter.
package ldpc_ram_arb_pkg;

  localparam int LDPC_RAM_DEFAULT_WIDTH   = 8;
  localparam int LDPC_RAM_DEFAULT_DEPTH   = 1024;
  localparam int LDPC_ARB_MAX_OUTSTANDING = 8;
  localparam int LDPC_ARB_MAX_REQ         = 8;

  // First set bit of valid at or after ptr, wrapping modulo num_req; returns ptr if none set.
  function automatic int rr_pick(input logic [LDPC_ARB_MAX_REQ-1:0] valid,
                                 input int ptr, input int num_req);
    int win;
    int idx;
    logic found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < LDPC_ARB_MAX_REQ; i++) begin
      idx = (ptr + i) % num_req;
      if (!found && (i < num_req) && valid[idx[2:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ldpc_ram_tag_fifo.sv
// In-order register FIFO holding the requester index of every read in flight.
module ldpc_ram_tag_fifo #(
  parameter  int TW    = 2,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  output logic [TW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);

  logic [TW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[PW-1:0]] <= push_tag;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_ram_rd_arbiter.sv
// Round-robin sharing of one ldpc_ram read port among NUM_REQ node units,
// with an in-order tag FIFO steering returned data back to its issuer.
module ldpc_ram_rd_arbiter
  import ldpc_ram_arb_pkg::*;
#(
  parameter  int WIDTH           = LDPC_RAM_DEFAULT_WIDTH,
  parameter  int DEPTH           = LDPC_RAM_DEFAULT_DEPTH,
  parameter  int NUM_REQ         = 4,
  parameter  int MAX_OUTSTANDING = LDPC_ARB_MAX_OUTSTANDING,
  localparam int AW              = $clog2(DEPTH),
  localparam int OW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_REQ*AW-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  input  logic [NUM_REQ-1:0]    i_rsp_ready,
  output logic [AW-1:0]         o_ram_addr,
  output logic                  o_ram_addr_valid,
  input  logic                  i_ram_addr_ready,
  input  logic [WIDTH-1:0]      i_ram_data,
  input  logic                  i_ram_valid,
  output logic                  o_ram_ready,
  output logic [OW-1:0]         o_outstanding,
  output logic                  o_err
);

  localparam int TW = $clog2(NUM_REQ);

  logic                        active;
  logic [TW-1:0]               rr_ptr;
  logic [TW-1:0]               grant;
  logic [TW-1:0]               grant_next;
  logic [TW-1:0]               head;
  logic [LDPC_ARB_MAX_REQ-1:0] valid_ext;
  logic                        full;
  logic                        empty;
  logic                        issue;
  logic                        ret;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = i_req_valid;
    grant                    = TW'(rr_pick(valid_ext, int'(rr_ptr), NUM_REQ));
  end

  assign grant_next = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;

  assign o_ram_addr_valid = active & (|i_req_valid) & ~full;
  assign o_ram_addr       = i_req_addr[int'(grant)*AW +: AW];
  assign issue            = o_ram_addr_valid & i_ram_addr_ready;

  always_comb begin
    o_req_ready = '0;
    if (issue) o_req_ready[grant] = 1'b1;
  end

  // With nothing in flight the RAM output is drained so stray words cannot wedge it.
  always_comb begin
    o_rsp_valid = '0;
    o_ram_ready = 1'b0;
    if (active) begin
      if (empty) begin
        o_ram_ready = 1'b1;
      end else begin
        o_rsp_valid[head] = i_ram_valid;
        o_ram_ready       = i_rsp_ready[head];
      end
    end
  end

  assign o_rsp_data = i_ram_data;
  assign ret        = i_ram_valid & o_ram_ready & ~empty;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active <= 1'b0;
      rr_ptr <= '0;
      o_err  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (issue) rr_ptr <= grant_next;
      if (active && empty && i_ram_valid) o_err <= 1'b1;
    end
  end

  ldpc_ram_tag_fifo #(
    .TW    (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (i_clock),
    .rst_n    (i_reset_n),
    .push     (issue),
    .push_tag (grant),
    .pop      (ret),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (o_outstanding)
  );

endmodule

// File: tb/tb_ldpc_ram_rd_arbiter.sv
// Directed bench for ldpc_ram_rd_arbiter with a 1-cycle-latency RAM model (mem[a] = a+100).
module tb_ldpc_ram_rd_arbiter;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 1024;
  localparam int NUM_REQ = 4;
  localparam int MAXO    = 8;
  localparam int AW      = 10;
  localparam int OW      = 4;

  logic                  i_clock = 1'b0;
  logic                  i_reset_n;
  logic [NUM_REQ*AW-1:0] i_req_addr;
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [WIDTH-1:0]      o_rsp_data;
  logic [NUM_REQ-1:0]    o_rsp_valid;
  logic [NUM_REQ-1:0]    i_rsp_ready;
  logic [AW-1:0]         o_ram_addr;
  logic                  o_ram_addr_valid;
  logic                  i_ram_addr_ready;
  logic [WIDTH-1:0]      i_ram_data;
  logic                  i_ram_valid;
  logic                  o_ram_ready;
  logic [OW-1:0]         o_outstanding;
  logic                  o_err;

  always #5 i_clock = ~i_clock;

  ldpc_ram_rd_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_ram_addr(o_ram_addr), .o_ram_addr_valid(o_ram_addr_valid),
    .i_ram_addr_ready(i_ram_addr_ready), .i_ram_data(i_ram_data),
    .i_ram_valid(i_ram_valid), .o_ram_ready(o_ram_ready),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [AW-1:0]    req_q [NUM_REQ][$];
  logic [AW-1:0]    ram_q [$];
  bit               stray;
  int               grant_log [$];
  int               rsp_idx_log [$];
  logic [WIDTH-1:0] rsp_data_log [$];
  int               peak_out;
  int               bad_onehot;

  function automatic logic [WIDTH-1:0] mem_val(input logic [AW-1:0] a);
    return WIDTH'(int'(a) + 100);
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_valid[k]          = (req_q[k].size() > 0);
      i_req_addr[k*AW +: AW]  = (req_q[k].size() > 0) ? req_q[k][0] : '0;
    end
    i_ram_valid = (ram_q.size() > 0) || stray;
    i_ram_data  = (ram_q.size() > 0) ? mem_val(ram_q[0]) : 8'hEE;
  endtask

  // One cycle: observe handshakes at negedge, update requesters/RAM just after posedge.
  task automatic tick();
    bit            iss;
    bit            ret;
    bit            do_pop;
    int            g;
    logic [AW-1:0] a;
    @(negedge i_clock);
    iss    = o_ram_addr_valid & i_ram_addr_ready;
    ret    = i_ram_valid & o_ram_ready;
    do_pop = 1'b0;
    g      = -1;
    a      = '0;
    if (int'(o_outstanding) > peak_out) peak_out = int'(o_outstanding);
    if ($countones(o_rsp_valid) > 1 || $countones(o_req_ready) > 1) bad_onehot++;
    if (iss) begin
      g = onehot_idx(o_req_ready);
      a = o_ram_addr;
      grant_log.push_back(g);
    end
    if (ret && (o_rsp_valid != '0)) begin
      rsp_idx_log.push_back(onehot_idx(o_rsp_valid));
      rsp_data_log.push_back(o_rsp_data);
    end
    if (ret && ram_q.size() > 0) do_pop = 1'b1;
    @(posedge i_clock);
    #1;
    if (do_pop) void'(ram_q.pop_front());
    if (iss) begin
      ram_q.push_back(a);
      if (g >= 0 && req_q[g].size() > 0) void'(req_q[g].pop_front());
    end
    drive();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_idx_log.delete();
    rsp_data_log.delete();
    peak_out   = 0;
    bad_onehot = 0;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NUM_REQ; k++) req_q[k].delete();
    ram_q.delete();
    stray = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    clear_stim();
    repeat (2) @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    @(posedge i_clock);
    #1;
    clear_logs();
  endtask

  task automatic wait_rsp(input int n, input int bound, input string tag);
    int c = 0;
    while (rsp_data_log.size() < n && c < bound) begin
      tick();
      c++;
    end
    check({tag, "_rsp_count"}, rsp_data_log.size(), n);
  endtask

  initial begin
    int c;
    i_reset_n        = 1'b0;
    i_rsp_ready      = '1;
    i_ram_addr_ready = 1'b1;
    i_req_addr       = '0;
    stray            = 1'b0;
    clear_logs();
    clear_stim();

    // reset state, with a request already pending
    req_q[0].push_back(10'd1);
    drive();
    #12;
    check("rst_req_ready", o_req_ready, 0);
    check("rst_addr_valid", o_ram_addr_valid, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_ram_ready", o_ram_ready, 0);
    check("rst_outstanding", o_outstanding, 0);
    check("rst_err", o_err, 0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    #1;
    check("inactive_addr_valid", o_ram_addr_valid, 0);
    check("inactive_ram_ready", o_ram_ready, 0);
    @(posedge i_clock);
    #1;
    check("active_addr_valid", o_ram_addr_valid, 1);
    check("active_req_ready", o_req_ready, 4'b0001);

    // single requester
    do_reset();
    i_rsp_ready = '1;
    req_q[2].push_back(10'd5);
    req_q[2].push_back(10'd6);
    req_q[2].push_back(10'd7);
    drive();
    wait_rsp(3, 20, "t1");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_idx%0d", i), (rsp_idx_log.size() > i) ? rsp_idx_log[i] : -1, 2);
      check($sformatf("t1_data%0d", i), (rsp_data_log.size() > i) ? rsp_data_log[i] : 0, 105 + i);
    end
    check("t1_grants", grant_log.size(), 3);
    check("t1_peak", (peak_out >= 1 && peak_out <= 2), 1);
    check("t1_onehot", bad_onehot, 0);

    // round-robin with all requesters busy
    do_reset();
    for (int k = 0; k < NUM_REQ; k++)
      for (int j = 0; j < 3; j++) req_q[k].push_back(AW'(k*10 + j));
    drive();
    wait_rsp(12, 60, "t2");
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t2_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, i % 4);
      check($sformatf("t2_idx%0d", i), (rsp_idx_log.size() > i) ? rsp_idx_log[i] : -1, i % 4);
      check($sformatf("t2_data%0d", i), (rsp_data_log.size() > i) ? rsp_data_log[i] : 0,
            (i % 4)*10 + i/4 + 100);
    end
    check("t2_onehot", bad_onehot, 0);

    // tag FIFO full stall
    do_reset();
    i_rsp_ready = '0;
    for (int j = 0; j < 12; j++) req_q[0].push_back(AW'(j));
    drive();
    repeat (15) tick();
    #1;
    check("t3_issues_at_full", grant_log.size(), 8);
    check("t3_addr_valid_full", o_ram_addr_valid, 0);
    check("t3_outstanding_full", o_outstanding, 8);
    check("t3_ram_ready_stalled", o_ram_ready, 0);
    i_rsp_ready = '1;
    wait_rsp(12, 60, "t3");
    check("t3_issues_total", grant_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t3_idx%0d", i), (rsp_idx_log.size() > i) ? rsp_idx_log[i] : -1, 0);
      check($sformatf("t3_data%0d", i), (rsp_data_log.size() > i) ? rsp_data_log[i] : 0, 100 + i);
    end
    check("t3_peak", peak_out, 8);

    // return backpressure from head requester 1
    do_reset();
    i_rsp_ready = 4'b1101;
    req_q[1].push_back(10'd20);
    req_q[2].push_back(10'd30);
    req_q[3].push_back(10'd40);
    drive();
    for (int s = 0; s < 3; s++) begin
      tick();
      #1;
      check($sformatf("t4_ram_ready%0d", s), o_ram_ready, 0);
      check($sformatf("t4_data_hold%0d", s), o_rsp_data, 120);
      check($sformatf("t4_rsp_valid%0d", s), o_rsp_valid, 4'b0010);
    end
    check("t4_none_delivered", rsp_data_log.size(), 0);
    i_rsp_ready = '1;
    wait_rsp(3, 20, "t4");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_idx%0d", i), (rsp_idx_log.size() > i) ? rsp_idx_log[i] : -1, i + 1);
      check($sformatf("t4_data%0d", i), (rsp_data_log.size() > i) ? rsp_data_log[i] : 0,
            120 + 10*i);
    end

    // stray return with empty FIFO
    do_reset();
    stray = 1'b1;
    drive();
    #1;
    check("t5_rsp_valid", o_rsp_valid, 0);
    check("t5_ram_ready", o_ram_ready, 1);
    check("t5_err_before", o_err, 0);
    tick();
    #1;
    check("t5_err_set", o_err, 1);
    stray = 1'b0;
    drive();
    tick();
    tick();
    #1;
    check("t5_err_sticky", o_err, 1);
    check("t5_rsp_valid_after", o_rsp_valid, 0);

    // reset with reads outstanding
    do_reset();
    i_rsp_ready = '0;
    for (int j = 0; j < 5; j++) req_q[0].push_back(AW'(50 + j));
    drive();
    c = 0;
    while (o_outstanding != 5 && c < 20) begin
      tick();
      c++;
    end
    #1;
    check("t6_outstanding_pre", o_outstanding, 5);
    i_reset_n = 1'b0;
    #1;
    check("t6_rst_outstanding", o_outstanding, 0);
    check("t6_rst_addr_valid", o_ram_addr_valid, 0);
    check("t6_rst_ram_ready", o_ram_ready, 0);
    check("t6_rst_rsp_valid", o_rsp_valid, 0);
    check("t6_rst_req_ready", o_req_ready, 0);
    clear_stim();
    i_rsp_ready = '1;
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    #1;
    check("t6_post_outstanding", o_outstanding, 0);
    check("t6_post_err", o_err, 0);
    @(posedge i_clock);
    #1;
    clear_logs();
    for (int k = 0; k < NUM_REQ; k++) req_q[k].push_back(AW'(60 + k));
    drive();
    tick();
    check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
